// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with private HI/LO registers and multi-cycle busy sequencing.
// Optional feature macro: MDU_MADD_EN enables madd (op 7) and maddu (op 8).
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        start,
   input  logic        RdSel,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);
   // state | meaning
   // IDLE  | no operation in flight, ops accepted
   // RUN   | mult/div counting down, result held in pend
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_t      state;
   logic [3:0]  cnt;
   logic [63:0] pend;
   logic        pend_wr;

   logic        is_mul, is_div, is_madd, is_signed;
   logic [63:0] ax, bx, prod, madd_res, div_res;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag, quo, rem;

   always_comb begin
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_madd   = 1'b0;
      is_signed = 1'b0;
      case (MDUOp)
         4'd1: begin is_mul = 1'b1; is_signed = 1'b1; end
         4'd2: is_mul = 1'b1;
         4'd3: begin is_div = 1'b1; is_signed = 1'b1; end
         4'd4: is_div = 1'b1;
`ifdef MDU_MADD_EN
         4'd7: begin is_mul = 1'b1; is_madd = 1'b1; is_signed = 1'b1; end
         4'd8: begin is_mul = 1'b1; is_madd = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Low 64 bits of a 64x64 product of extended operands give the exact 32x32 result.
   assign ax       = is_signed ? {{32{A[31]}}, A} : {32'b0, A};
   assign bx       = is_signed ? {{32{B[31]}}, B} : {32'b0, B};
   assign prod     = ax * bx;
   assign madd_res = {HI, LO} + prod;

   assign a_neg   = is_signed & A[31];
   assign b_neg   = is_signed & B[31];
   assign a_mag   = a_neg ? -A : A;
   assign b_mag   = b_neg ? -B : B;
   assign b_den   = (B == 32'd0) ? 32'd1 : b_mag;
   assign q_mag   = a_mag / b_den;
   assign r_mag   = a_mag % b_den;
   assign quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem     = a_neg ? -r_mag : r_mag;
   assign div_res = {rem, quo};

   assign MDUOut = RdSel ? HI : LO;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= 4'd0;
         pend    <= 64'd0;
         pend_wr <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_mul || is_div) begin
                     state   <= RUN;
                     busy    <= 1'b1;
                     cnt     <= is_div ? DIV_N : MULT_N;
                     pend    <= is_div ? div_res : (is_madd ? madd_res : prod);
                     pend_wr <= ~(is_div && (B == 32'd0));
                  end else if (MDUOp == 4'd5) begin
                     HI <= A;
                  end else if (MDUOp == 4'd6) begin
                     LO <= A;
                  end
               end
            end
            RUN: begin
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= 4'd0;
                  if (pend_wr) begin
                     HI <= pend[63:32];
                     LO <= pend[31:0];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
